// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit for the EX stage.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division,
// both on operand magnitudes with a sign fix-up on the final iteration.
// MTHI/MTLO write the architectural HI/LO registers directly from idle.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       mdop,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               start_mul;
  logic               start_div;
  logic               start_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Decode the request and form operand magnitudes for signed operations
  always_comb begin
    start_mul    = (mdop == OP_MULT) || (mdop == OP_MULTU);
    start_div    = (mdop == OP_DIV)  || (mdop == OP_DIVU);
    start_signed = (mdop == OP_MULT) || (mdop == OP_DIV);
    a_mag        = (start_signed && A[WIDTH-1]) ? -A : A;
    b_mag        = (start_signed && B[WIDTH-1]) ? -B : B;
  end

  // One shift-add or restoring-divide iteration plus the sign-corrected results
  always_comb begin
    mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, work[WIDTH-1:1]};
    rem_sh   = work[2*WIDTH-1:WIDTH-1];
    div_ge   = (rem_sh >= {1'b0, opnd});
    rem_new  = div_ge ? (rem_sh[WIDTH-1:0] - opnd) : rem_sh[WIDTH-1:0];
    div_next = {rem_new, work[WIDTH-2:0], div_ge};
    step     = is_div ? div_next : mul_next;
    prod_fix = neg_q ? -step : step;
    quot_fix = div_zero ? '1 : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
    rem_fix  = neg_r ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  end

  // Control FSM, iteration datapath and the HI/LO architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      work     <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_mul || start_div) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            is_div   <= start_div;
            neg_q    <= start_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r    <= start_signed & A[WIDTH-1];
            div_zero <= (B == '0);
            if (start_div) begin
              work <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              work <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end else if (mdop == OP_MTHI) begin
            hi <= A;
          end else if (mdop == OP_MTLO) begin
            lo <= A;
          end
        end
        ST_RUN: begin
          if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            work <= step;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_ITER) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (is_div) begin
                lo <= quot_fix;
                hi <= rem_fix;
              end else begin
                {hi, lo} <= prod_fix;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for the mdu multiply/divide unit.
// Directed vector table, hand-written multi-cycle sequences, and random
// operations checked against an arithmetic reference model.
module tb_mdu;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  mdop;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mhi;
  logic [31:0] mlo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    string       name;
  } vec_t;

  vec_t vecs[9];

  mdu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .mdop   (mdop),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case the bench itself stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request for one cycle; returns #1 after the sampling edge (cycle 1)
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mdop = op;
    A    = a;
    B    = b;
    @(posedge clk);
    #1;
    mdop = OP_NONE;
  endtask

  // Arithmetic reference for the four iterative operations
  function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
    longint          p;
    longint unsigned pu;
    int              sa;
    int              sb;
    sa = a;
    sb = b;
    rh = '0;
    rl = '0;
    case (op)
      OP_MULT: begin
        p  = longint'(sa) * longint'(sb);
        rh = p[63:32];
        rl = p[31:0];
      end
      OP_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        rh = pu[63:32];
        rl = pu[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          rl = 32'hFFFFFFFF;
          rh = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          rl = 32'h80000000;
          rh = 32'd0;
        end else begin
          rl = sa / sb;
          rh = sa % sb;
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          rl = 32'hFFFFFFFF;
          rh = a;
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
      default: begin
        rh = '0;
        rl = '0;
      end
    endcase
  endfunction

  // Full operation: busy window, HI/LO hold during run, result and done in cycle 33
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo, input string name);
    int badBusy;
    badBusy = 0;
    applyStimulus(op, a, b);
    for (int c = 1; c <= 32; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (busy !== 1'b1 || done !== 1'b0) badBusy++;
      if (c == 32) begin
        checkOutput({name, "_hi_hold"}, hi, mhi);
        checkOutput({name, "_lo_hold"}, lo, mlo);
      end
    end
    checkOutput({name, "_busy_window"}, badBusy, 0);
    @(posedge clk);
    #1;
    checkOutput({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({name, "_hi"}, hi, expHi);
    checkOutput({name, "_lo"}, lo, expLo);
    mhi = expHi;
    mlo = expLo;
  endtask

  // Main test sequence
  initial begin
    int          bad;
    int          doneCycle;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rh;
    logic [31:0] rl;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg"};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, "multu"};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg"};
    vecs[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu"};
    vecs[4] = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, "divu_zero"};
    vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
    vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_negdivisor"};
    vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin"};
    vecs[8] = '{OP_DIV,   32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 32'hFFFFFFFF, "div_zero_neg"};

    rst_n  = 1'b0;
    A      = '0;
    B      = '0;
    mdop   = OP_NONE;
    cancel = 1'b0;
    mhi    = '0;
    mlo    = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(OP_MTHI, 32'h11111111, 32'd0);
    checkOutput("mthi_idle", hi, 32'h11111111);
    applyStimulus(OP_MTLO, 32'h11111111, 32'd0);
    checkOutput("mtlo_idle", lo, 32'h11111111);
    checkOutput("mtlo_hi_kept", hi, 32'h11111111);
    mhi = 32'h11111111;
    mlo = 32'h11111111;

    applyStimulus(OP_DIV, 32'h00001000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    checkOutput("cancel_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    checkOutput("cancel_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("cancel_done", {31'd0, done}, 32'd0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== mhi || lo !== mlo) bad++;
    end
    checkOutput("cancel_quiet", bad, 0);
    checkOutput("cancel_hi", hi, 32'h11111111);
    checkOutput("cancel_lo", lo, 32'h11111111);

    for (int i = 0; i < 9; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, vecs[i].name);
    end

    applyStimulus(OP_MULT, 32'd5, 32'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    mdop = OP_MTHI;
    A    = 32'hAAAA5555;
    B    = 32'd0;
    @(posedge clk);
    #1;
    mdop = OP_NONE;
    checkOutput("busy_mthi_ignored", hi, mhi);
    checkOutput("busy_during_mthi", {31'd0, busy}, 32'd1);
    doneCycle = 0;
    for (int c = 6; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && doneCycle == 0) doneCycle = c;
    end
    checkOutput("busy_mthi_done_cycle", doneCycle, 33);
    checkOutput("busy_mthi_hi", hi, 32'd0);
    checkOutput("busy_mthi_lo", lo, 32'd35);
    mhi = 32'd0;
    mlo = 32'd35;

    @(negedge clk);
    mdop   = OP_MTHI;
    A      = 32'h0BADF00D;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    mdop   = OP_NONE;
    cancel = 1'b0;
    checkOutput("idle_cancel_mthi", hi, 32'h0BADF00D);
    @(negedge clk);
    mdop   = OP_MULTU;
    A      = 32'hFFFFFFFF;
    B      = 32'hFFFFFFFF;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    mdop   = OP_NONE;
    cancel = 1'b0;
    checkOutput("idle_cancel_accept", {31'd0, busy}, 32'd1);
    repeat (32) begin
      @(posedge clk);
      #1;
    end
    checkOutput("idle_cancel_done", {31'd0, done}, 32'd1);
    checkOutput("idle_cancel_hi", hi, 32'hFFFFFFFE);
    checkOutput("idle_cancel_lo", lo, 32'h00000001);

    applyStimulus(OP_MULT, 32'd3, 32'd5);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_hi", hi, 32'd0);
    checkOutput("midreset_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mhi = '0;
    mlo = '0;
    runOp(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "after_reset");

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      refModel(rop, ra, rb, rh, rl);
      runOp(rop, ra, rb, rh, rl, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
